input_vc_buffer: RTL and testbench

Per-virtual-channel input buffer of the router input port, sitting directly upstream of the route computation unit. Stores incoming flits in a circular FIFO, presents the head flit's destination fields to route computation, registers the returned output port, and sequences the packet through VC allocation and switch allocation with a three-state machine. One instance per VC per input port.

---
 rtl/noc_params.sv | 35 +++
 rtl/circular_buffer.sv | 47 ++++
 rtl/input_vc_buffer.sv | 129 ++++++++++++
 tb/tb_input_vc_buffer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_params.sv
// rtl/noc_params.sv - shared NoC router types: flit layout, labels, ports, input VC states
package noc_params;

  localparam int VC_NUM           = 4;
  localparam int VC_SIZE          = $clog2(VC_NUM);
  localparam int FLIT_DEST_X_W    = 4;
  localparam int FLIT_DEST_Y_W    = 4;
  localparam int DEST_ADDR_SIZE_L = 2;
  localparam int PAYLOAD_SIZE     = 16;

  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

  // DLA0 is the local/ejection port and doubles as the idle output port value
  typedef enum logic [2:0] {DLA0, NORTH, SOUTH, EAST, WEST} port_t;

  typedef enum logic [1:0] {IDLE, VA, SA} input_vc_state_t;

  typedef struct packed {
    flit_label_t                 label;
    logic [VC_SIZE-1:0]          vc_id;
    logic [FLIT_DEST_X_W-1:0]    x_dest;
    logic [FLIT_DEST_Y_W-1:0]    y_dest;
    logic [DEST_ADDR_SIZE_L-1:0] l_dest;
    logic [PAYLOAD_SIZE-1:0]     payload;
  } flit_t;

  function automatic logic is_head(input flit_label_t label);
    return (label == HEAD) || (label == HEADTAIL);
  endfunction

  function automatic logic is_tail(input flit_label_t label);
    return (label == TAIL) || (label == HEADTAIL);
  endfunction

endpackage

// File: rtl/circular_buffer.sv
// rtl/circular_buffer.sv - circular flit FIFO with wrapping pointers and occupancy count
module circular_buffer
  import noc_params::*;
#(
  parameter int BUFFER_SIZE = 8
) (
  input  logic  clk,
  input  logic  rst_n,
  input  flit_t data_i,
  input  logic  write_i,
  input  logic  read_i,
  output flit_t data_o,
  output logic  is_full_o,
  output logic  is_empty_o
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(BUFFER_SIZE);

  flit_t            mem [BUFFER_SIZE];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;

  // Caller guarantees write_i only when not full or popping, read_i only when not empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (write_i) wr_ptr <= wr_ptr + 1'b1;
      if (read_i)  rd_ptr <= rd_ptr + 1'b1;
      if (write_i && !read_i)      count <= count + 1'b1;
      else if (read_i && !write_i) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (write_i) mem[wr_ptr] <= data_i;
  end

  assign data_o     = mem[rd_ptr];
  assign is_full_o  = (count == FULL_COUNT);
  assign is_empty_o = (count == '0);

endmodule

// File: rtl/input_vc_buffer.sv
// rtl/input_vc_buffer.sv - per-VC input buffer with IDLE/VA/SA sequencing; NOC_INPUT_BUFFER_ERR_EN enables error_o
module input_vc_buffer
  import noc_params::*;
#(
  parameter int BUFFER_SIZE      = 8,
  parameter int DEST_ADDR_SIZE_X = 4,
  parameter int DEST_ADDR_SIZE_Y = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  flit_t                       data_i,
  input  logic                        valid_flit_i,
  output logic [DEST_ADDR_SIZE_X-1:0] x_dest_o,
  output logic [DEST_ADDR_SIZE_Y-1:0] y_dest_o,
  output logic [DEST_ADDR_SIZE_L-1:0] l_dest_o,
  input  port_t                       out_port_i,
  input  logic                        va_done_i,
  input  logic [VC_SIZE-1:0]          vc_new_i,
  input  logic                        sa_grant_i,
  output logic                        va_request_o,
  output logic                        sa_request_o,
  output port_t                       out_port_o,
  output logic                        vc_allocatable_o,
  output flit_t                       data_o,
  output logic                        is_full_o,
  output logic                        is_empty_o,
  output logic                        error_o
);

  flit_t              head;
  input_vc_state_t    state, state_next;
  port_t              out_port_next;
  logic [VC_SIZE-1:0] vc_reg, vc_next;
  logic               pop, push;

  assign pop  = (state == SA) && sa_grant_i && !is_empty_o;
  assign push = valid_flit_i && (!is_full_o || pop);

  circular_buffer #(.BUFFER_SIZE(BUFFER_SIZE)) u_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_i     (data_i),
    .write_i    (push),
    .read_i     (pop),
    .data_o     (head),
    .is_full_o  (is_full_o),
    .is_empty_o (is_empty_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      out_port_o <= DLA0;
      vc_reg     <= '0;
    end else begin
      state      <= state_next;
      out_port_o <= out_port_next;
      vc_reg     <= vc_next;
    end
  end

  // vc_allocatable_o follows the grant combinationally so the release lines up with the tail pop
  always_comb begin
    state_next       = state;
    out_port_next    = out_port_o;
    vc_next          = vc_reg;
    va_request_o     = 1'b0;
    sa_request_o     = 1'b0;
    vc_allocatable_o = 1'b0;
    unique case (state)
      IDLE: begin
        if (!is_empty_o && is_head(head.label)) begin
          out_port_next = out_port_i;
          state_next    = VA;
        end
      end
      VA: begin
        va_request_o = 1'b1;
        if (va_done_i) begin
          vc_next    = vc_new_i;
          state_next = SA;
        end
      end
      SA: begin
        sa_request_o = !is_empty_o;
        if (pop && is_tail(head.label)) begin
          vc_allocatable_o = 1'b1;
          state_next       = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    data_o       = head;
    data_o.vc_id = vc_reg;
  end

  assign x_dest_o = head.x_dest;
  assign y_dest_o = head.y_dest;
  assign l_dest_o = head.l_dest;

`ifdef NOC_INPUT_BUFFER_ERR_EN
  logic mid_pkt;
  logic error_q;
  logic err_event;

  assign err_event = (valid_flit_i && is_full_o && !pop)
                   || (sa_grant_i && !pop)
                   || (state == IDLE && !is_empty_o && !is_head(head.label))
                   || (state == SA && !is_empty_o && mid_pkt && is_head(head.label));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mid_pkt <= 1'b0;
      error_q <= 1'b0;
    end else begin
      if (pop) mid_pkt <= !is_tail(head.label);
      error_q <= error_q | err_event;
    end
  end

  assign error_o = error_q;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_input_vc_buffer.sv
// tb/tb_input_vc_buffer.sv - randomized self-checking bench for input_vc_buffer against a flit-queue model
module tb_input_vc_buffer;
  import noc_params::*;

  localparam int DEPTH = 8;
`ifdef NOC_INPUT_BUFFER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  flit_t              data_i = '0;
  logic               valid_flit_i = 1'b0;
  logic [3:0]         x_dest_o;
  logic [3:0]         y_dest_o;
  logic [DEST_ADDR_SIZE_L-1:0] l_dest_o;
  port_t              out_port_i = DLA0;
  logic               va_done_i = 1'b0;
  logic [VC_SIZE-1:0] vc_new_i = '0;
  logic               sa_grant_i = 1'b0;
  logic               va_request_o, sa_request_o, vc_allocatable_o;
  port_t              out_port_o;
  flit_t              data_o;
  logic               is_full_o, is_empty_o, error_o;

  int checks = 0;
  int errors = 0;
  flit_t model_q[$];
  logic exp_err = 1'b0;
  logic [VC_SIZE-1:0] cur_vc = '0;

  input_vc_buffer #(.BUFFER_SIZE(DEPTH), .DEST_ADDR_SIZE_X(4), .DEST_ADDR_SIZE_Y(4)) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_flit_i(valid_flit_i),
    .x_dest_o(x_dest_o), .y_dest_o(y_dest_o), .l_dest_o(l_dest_o),
    .out_port_i(out_port_i), .va_done_i(va_done_i), .vc_new_i(vc_new_i),
    .sa_grant_i(sa_grant_i), .va_request_o(va_request_o), .sa_request_o(sa_request_o),
    .out_port_o(out_port_o), .vc_allocatable_o(vc_allocatable_o), .data_o(data_o),
    .is_full_o(is_full_o), .is_empty_o(is_empty_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  function automatic flit_t mk(input flit_label_t l);
    flit_t f;
    f.label   = l;
    f.vc_id   = VC_SIZE'($urandom);
    f.x_dest  = FLIT_DEST_X_W'($urandom);
    f.y_dest  = FLIT_DEST_Y_W'($urandom);
    f.l_dest  = DEST_ADDR_SIZE_L'($urandom);
    f.payload = PAYLOAD_SIZE'($urandom);
    return f;
  endfunction

  function automatic port_t rand_port();
    return port_t'($urandom_range(0, 4));
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; valid_flit_i = 1'b0; va_done_i = 1'b0; sa_grant_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_q.delete();
    exp_err = 1'b0;
  endtask

  task automatic write_flit(input flit_t f);
    data_i = f; valid_flit_i = 1'b1;
    @(posedge clk); #1;
    valid_flit_i = 1'b0;
    if (model_q.size() < DEPTH) model_q.push_back(f);
    else exp_err = ERR_EN;
  endtask

  task automatic wait_va(output bit ok);
    int n;
    n = 0;
    while (va_request_o !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
    ok = (va_request_o === 1'b1);
    checks++;
    if (!ok) begin errors++; $display("FAIL va_wait: va_request_o=%b required 1 within 10 cycles", va_request_o); end
  endtask

  task automatic do_va(input port_t exp_port);
    logic [VC_SIZE-1:0] vc;
    checks++;
    if (out_port_o !== exp_port) begin errors++; $display("FAIL out_port: got %0d required %0d", out_port_o, exp_port); end
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
      checks++;
      if (va_request_o !== 1'b1) begin errors++; $display("FAIL va_hold: va_request_o=%b required 1", va_request_o); end
    end
    vc = VC_SIZE'($urandom);
    vc_new_i = vc; va_done_i = 1'b1;
    @(posedge clk); #1;
    va_done_i = 1'b0; cur_vc = vc;
    checks++;
    if (va_request_o !== 1'b0 || sa_request_o !== 1'b1)
      begin errors++; $display("FAIL va_to_sa: va_req=%b sa_req=%b required 0 1", va_request_o, sa_request_o); end
  endtask

  task automatic drain_sa(input bit always_grant, output bit ok);
    bit done, g;
    int n;
    flit_t exp;
    done = 1'b0; n = 0;
    while (!done && n < 40 && model_q.size() > 0) begin
      g = always_grant || ($urandom_range(0, 3) != 0);
      exp = model_q[0];
      exp.vc_id = cur_vc;
      checks++;
      if (sa_request_o !== 1'b1) begin errors++; $display("FAIL sa_request: got %b required 1", sa_request_o); end
      sa_grant_i = g;
      #1;
      checks++;
      if (data_o !== exp) begin errors++; $display("FAIL data_o: got %h required %h", data_o, exp); end
      checks++;
      if (vc_allocatable_o !== (g && is_tail(exp.label)))
        begin errors++; $display("FAIL vc_allocatable: got %b required %b", vc_allocatable_o, g && is_tail(exp.label)); end
      @(posedge clk); #1;
      sa_grant_i = 1'b0;
      if (g) begin done = is_tail(exp.label); void'(model_q.pop_front()); end
      n++;
    end
    ok = done;
    checks++;
    if (!done) begin errors++; $display("FAIL drain: tail not popped within budget, model size %0d", model_q.size()); end
  endtask

  task automatic process_packets(input bit always_grant);
    port_t exp_port;
    bit ok;
    exp_port = out_port_i;
    while (model_q.size() > 0) begin
      wait_va(ok);
      if (!ok) return;
      do_va(exp_port);
      drain_sa(always_grant, ok);
      if (!ok) return;
      out_port_i = rand_port();
      exp_port = out_port_i;
    end
    checks++;
    if (is_empty_o !== 1'b1) begin errors++; $display("FAIL drained_empty: is_empty_o=%b required 1", is_empty_o); end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (is_empty_o !== 1'b1 || is_full_o !== 1'b0 || va_request_o !== 1'b0 || sa_request_o !== 1'b0 ||
        vc_allocatable_o !== 1'b0 || out_port_o !== DLA0 || error_o !== 1'b0 || data_o.vc_id !== '0)
      begin errors++; $display("FAIL reset: empty=%b full=%b va=%b sa=%b alloc=%b port=%0d err=%b vc=%0d",
        is_empty_o, is_full_o, va_request_o, sa_request_o, vc_allocatable_o, out_port_o, error_o, data_o.vc_id); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_headtail();
    flit_t f;
    do_reset();
    out_port_i = EAST;
    f = mk(HEADTAIL); f.x_dest = 4'd2; f.y_dest = 4'd3; f.l_dest = 2'd1;
    write_flit(f);
    checks++;
    if (is_empty_o !== 1'b0 || va_request_o !== 1'b0 || x_dest_o !== 4'd2 || y_dest_o !== 4'd3 || l_dest_o !== 2'd1)
      begin errors++; $display("FAIL ht_head: empty=%b va=%b dest=%0d,%0d,%0d required 0 0 2,3,1",
        is_empty_o, va_request_o, x_dest_o, y_dest_o, l_dest_o); end
    @(posedge clk); #1;
    checks++;
    if (va_request_o !== 1'b1) begin errors++; $display("FAIL ht_va: va_request_o=%b required 1", va_request_o); end
    vc_new_i = 2'd2; va_done_i = 1'b1;
    @(posedge clk); #1;
    va_done_i = 1'b0;
    checks++;
    if (sa_request_o !== 1'b1 || out_port_o !== EAST)
      begin errors++; $display("FAIL ht_sa: sa_req=%b port=%0d required 1 %0d", sa_request_o, out_port_o, EAST); end
    sa_grant_i = 1'b1; #1;
    checks++;
    if (data_o.vc_id !== 2'd2 || vc_allocatable_o !== 1'b1)
      begin errors++; $display("FAIL ht_grant: vc_id=%0d alloc=%b required 2 1", data_o.vc_id, vc_allocatable_o); end
    @(posedge clk); #1;
    sa_grant_i = 1'b0; model_q.delete();
    checks++;
    if (is_empty_o !== 1'b1 || sa_request_o !== 1'b0 || va_request_o !== 1'b0 || vc_allocatable_o !== 1'b0)
      begin errors++; $display("FAIL ht_done: empty=%b sa=%b va=%b alloc=%b required 1 0 0 0",
        is_empty_o, sa_request_o, va_request_o, vc_allocatable_o); end
  endtask

  task automatic test_multi_flit();
    do_reset();
    out_port_i = rand_port();
    write_flit(mk(HEAD)); write_flit(mk(BODY)); write_flit(mk(BODY)); write_flit(mk(TAIL));
    process_packets(1'b1);
  endtask

  task automatic test_random_packets();
    int len, used;
    for (int it = 0; it < 8; it++) begin
      out_port_i = rand_port();
      used = 0;
      for (int p = 0; p < 3; p++) begin
        len = $urandom_range(1, 3);
        if (used + len > DEPTH) break;
        if (len == 1) write_flit(mk(HEADTAIL));
        else begin
          write_flit(mk(HEAD));
          for (int b = 0; b < len - 2; b++) write_flit(mk(BODY));
          write_flit(mk(TAIL));
        end
        used += len;
      end
      process_packets(1'b0);
    end
  endtask

  task automatic test_full();
    port_t p0;
    flit_t f;
    bit ok;
    do_reset();
    out_port_i = rand_port(); p0 = out_port_i;
    write_flit(mk(HEAD));
    for (int i = 0; i < 6; i++) write_flit(mk(BODY));
    write_flit(mk(TAIL));
    checks++;
    if (is_full_o !== 1'b1) begin errors++; $display("FAIL full_8: is_full_o=%b required 1", is_full_o); end
    write_flit(mk(HEADTAIL));
    checks++;
    if (is_full_o !== 1'b1 || error_o !== exp_err)
      begin errors++; $display("FAIL full_drop: full=%b err=%b required 1 %b", is_full_o, error_o, exp_err); end
    wait_va(ok);
    if (!ok) return;
    do_va(p0);
    f = mk(HEADTAIL);
    data_i = f; valid_flit_i = 1'b1; sa_grant_i = 1'b1;
    @(posedge clk); #1;
    valid_flit_i = 1'b0; sa_grant_i = 1'b0;
    void'(model_q.pop_front());
    model_q.push_back(f);
    checks++;
    if (is_full_o !== 1'b1) begin errors++; $display("FAIL full_wr_pop: is_full_o=%b required 1", is_full_o); end
    drain_sa(1'b1, ok);
    if (!ok) return;
    process_packets(1'b0);
  endtask

  task automatic test_body_idle();
    do_reset();
    write_flit(mk(BODY));
    exp_err = ERR_EN;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (va_request_o !== 1'b0 || is_empty_o !== 1'b0)
        begin errors++; $display("FAIL body_idle: va=%b empty=%b required 0 0", va_request_o, is_empty_o); end
    end
    checks++;
    if (error_o !== exp_err) begin errors++; $display("FAIL body_idle_err: error_o=%b required %b", error_o, exp_err); end
  endtask

  task automatic test_grant_in_va();
    flit_t h;
    do_reset();
    out_port_i = rand_port();
    h = mk(HEAD);
    write_flit(h);
    @(posedge clk); #1;
    checks++;
    if (va_request_o !== 1'b1) begin errors++; $display("FAIL gva_va: va_request_o=%b required 1", va_request_o); end
    sa_grant_i = 1'b1;
    @(posedge clk); #1;
    sa_grant_i = 1'b0;
    exp_err = ERR_EN;
    checks++;
    if (is_empty_o !== 1'b0 || data_o.payload !== h.payload || va_request_o !== 1'b1 || error_o !== exp_err)
      begin errors++; $display("FAIL gva_nopop: empty=%b payload=%h va=%b err=%b required 0 %h 1 %b",
        is_empty_o, data_o.payload, va_request_o, error_o, h.payload, exp_err); end
    write_flit(mk(TAIL));
    process_packets(1'b0);
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    out_port_i = EAST;
    write_flit(mk(HEAD)); write_flit(mk(BODY)); write_flit(mk(BODY));
    wait_va(ok);
    if (!ok) return;
    vc_new_i = 2'd3; va_done_i = 1'b1;
    @(posedge clk); #1;
    va_done_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (is_empty_o !== 1'b1 || is_full_o !== 1'b0 || sa_request_o !== 1'b0 || va_request_o !== 1'b0 ||
        vc_allocatable_o !== 1'b0 || out_port_o !== DLA0 || data_o.vc_id !== '0 || error_o !== 1'b0)
      begin errors++; $display("FAIL reset_mid: empty=%b full=%b sa=%b va=%b alloc=%b port=%0d vc=%0d err=%b",
        is_empty_o, is_full_o, sa_request_o, va_request_o, vc_allocatable_o, out_port_o, data_o.vc_id, error_o); end
    model_q.delete();
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (is_empty_o !== 1'b1 || va_request_o !== 1'b0)
      begin errors++; $display("FAIL reset_mid_idle: empty=%b va=%b required 1 0", is_empty_o, va_request_o); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_headtail();
    test_multi_flit();
    test_random_packets();
    test_full();
    test_body_idle();
    test_grant_in_va();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
